// File: rtl/configurable_full_adder_unit.sv
// Parameterised ripple-carry adder with registered sum, carry-out,
// signed-overflow flag and a one-cycle valid handshake.
module configurable_full_adder_unit #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             out_valid
);

   // carry[i] is the carry into bit i; carry[WIDTH] is the carry out of the MSB
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;
   logic             overflow_d;

   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             overflow_q;
   logic             out_valid_q;

   assign carry[0] = cin;

   // One full-adder cell per bit, chained through carry
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      logic p;
      assign p          = a[i] ^ b[i];
      assign sum_d[i]   = p ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & p);
   end

   // Signed overflow: carry into the MSB differs from carry out of it
   // (for WIDTH=1 the carry into the MSB is cin itself)
   always_comb begin
      overflow_d = carry[WIDTH] ^ carry[WIDTH-1];
   end

   // Result registers: reset wins, results load only on accepted inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q       <= '0;
         cout_q      <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            sum_q      <= sum_d;
            cout_q     <= carry[WIDTH];
            overflow_q <= overflow_d;
         end
      end
   end

   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_configurable_full_adder_unit.sv
// Directed and randomised checks of configurable_full_adder_unit at
// WIDTH = 8, 16 and 1, sharing one clock and reset.
module tb_configurable_full_adder_unit;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic       v8,  c8,  co8,  ov8,  vo8;
   logic [7:0] a8,  b8,  s8;
   logic        v16, c16, co16, ov16, vo16;
   logic [15:0] a16, b16, s16;
   logic v1, c1, a1, b1, s1, co1, ov1, vo1;

   int errors = 0;
   int checks = 0;

   logic [8:0]  e8;
   logic [16:0] e16;
   logic        eo8, eo16;

   configurable_full_adder_unit #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
      .sum(s8), .cout(co8), .overflow(ov8), .out_valid(vo8)
   );

   configurable_full_adder_unit #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
      .sum(s16), .cout(co16), .overflow(ov16), .out_valid(vo16)
   );

   configurable_full_adder_unit #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
      .sum(s1), .cout(co1), .overflow(ov1), .out_valid(vo1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] s, input logic co, input logic ov,
                       input logic vo);
      chk({tag, "_sum"},  64'(s8),  64'(s));
      chk({tag, "_cout"}, 64'(co8), 64'(co));
      chk({tag, "_ovf"},  64'(ov8), 64'(ov));
      chk({tag, "_vld"},  64'(vo8), 64'(vo));
   endtask

   task automatic chk16(input string tag, input logic [15:0] s, input logic co, input logic ov,
                        input logic vo);
      chk({tag, "_sum"},  64'(s16),  64'(s));
      chk({tag, "_cout"}, 64'(co16), 64'(co));
      chk({tag, "_ovf"},  64'(ov16), 64'(ov));
      chk({tag, "_vld"},  64'(vo16), 64'(vo));
   endtask

   task automatic chk1(input string tag, input logic s, input logic co, input logic ov,
                       input logic vo);
      chk({tag, "_sum"},  64'(s1),  64'(s));
      chk({tag, "_cout"}, 64'(co1), 64'(co));
      chk({tag, "_ovf"},  64'(ov1), 64'(ov));
      chk({tag, "_vld"},  64'(vo1), 64'(vo));
   endtask

   initial begin
      rst = 1'b1;
      v8 = 1'b0;  a8 = '0;  b8 = '0;  c8 = 1'b0;
      v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
      v1 = 1'b0;  a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      tick();
      tick();
      chk8("rst8", 8'h00, 1'b0, 1'b0, 1'b0);
      chk16("rst16", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk1("rst1", 1'b0, 1'b0, 1'b0, 1'b0);

      // 8-bit directed, issued back to back
      rst = 1'b0;
      v8 = 1'b1; a8 = 8'h19; b8 = 8'h26; c8 = 1'b0;
      tick();
      chk8("add_19_26", 8'h3F, 1'b0, 1'b0, 1'b1);
      a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b1;
      tick();
      chk8("add_f0_0f_c", 8'h00, 1'b1, 1'b0, 1'b1);
      a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
      tick();
      chk8("add_7f_01", 8'h80, 1'b0, 1'b1, 1'b1);
      a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
      tick();
      chk8("wrap_ff_c", 8'h00, 1'b1, 1'b0, 1'b1);
      a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
      tick();
      chk8("add_80_80", 8'h00, 1'b1, 1'b1, 1'b1);

      // Idle with unknown operands: last result holds, valid drops
      v8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
      tick();
      chk8("hold1", 8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      chk8("hold2", 8'h00, 1'b1, 1'b1, 1'b0);

      a8 = 8'h12; b8 = 8'h34; c8 = 1'b1; v8 = 1'b1;
      tick();
      chk8("add_12_34_c", 8'h47, 1'b0, 1'b0, 1'b1);

      // Reset beats a valid input
      rst = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
      tick();
      chk8("rst_prio", 8'h00, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; v8 = 1'b0;
      tick();
      chk8("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

      // 16-bit directed
      v16 = 1'b1; a16 = 16'h1919; b16 = 16'h2626; c16 = 1'b0;
      tick();
      chk16("add16_a", 16'h3F3F, 1'b0, 1'b0, 1'b1);
      a16 = 16'hF0F0; b16 = 16'h0F0F; c16 = 1'b1;
      tick();
      chk16("add16_b", 16'h0000, 1'b1, 1'b0, 1'b1);
      a16 = 16'h7FFF; b16 = 16'h0000; c16 = 1'b1;
      tick();
      chk16("add16_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
      v16 = 1'b0;
      tick();
      chk16("hold16", 16'h8000, 1'b0, 1'b1, 1'b0);

      // 1-bit: overflow reduces to cin ^ cout
      v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      tick();
      chk1("w1_111", 1'b1, 1'b1, 1'b0, 1'b1);
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
      tick();
      chk1("w1_001", 1'b1, 1'b0, 1'b1, 1'b1);
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
      tick();
      chk1("w1_110", 1'b0, 1'b1, 1'b1, 1'b1);
      v1 = 1'b0;
      tick();
      chk1("w1_hold", 1'b0, 1'b1, 1'b1, 1'b0);

      // Random vectors on both wide instances, continuous valid
      v8 = 1'b1; v16 = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
         e8   = {1'b0, a8} + {1'b0, b8} + 9'(c8);
         e16  = {1'b0, a16} + {1'b0, b16} + 17'(c16);
         eo8  = (a8[7] == b8[7]) && (e8[7] != a8[7]);
         eo16 = (a16[15] == b16[15]) && (e16[15] != a16[15]);
         tick();
         chk("rnd8_res",   64'({co8, s8}),   64'(e8));
         chk("rnd8_ovf",   64'(ov8),         64'(eo8));
         chk("rnd8_vld",   64'(vo8),         64'd1);
         chk("rnd16_res",  64'({co16, s16}), 64'(e16));
         chk("rnd16_ovf",  64'(ov16),        64'(eo16));
         chk("rnd16_vld",  64'(vo16),        64'd1);
      end
      v8 = 1'b0; v16 = 1'b0;
      tick();
      chk("rnd8_idle",  64'(vo8),  64'd0);
      chk("rnd16_idle", 64'(vo16), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
